// File: rtl/tsc_pkg.sv
// Shared types and constants for the rare-event trigger counter.
package tsc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRED
  } tsc_state_t;

  localparam int unsigned TSC_MODE_STICKY = 0;
  localparam int unsigned TSC_MODE_PULSE  = 1;

  // Idle counter must hold the value TIMEOUT itself; never narrower than one bit.
  function automatic int unsigned tsc_idle_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/tsc_window.sv
// Free-running phase counter; the activation window is open while the phase MSB is set.
module tsc_window #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             window,
  output logic [CNT_W-1:0] phase
);

  logic [CNT_W-1:0] phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + CNT_W'(1);
    end
  end

  assign phase  = phase_q;
  assign window = phase_q[CNT_W-1];

endmodule

// File: rtl/tsc_multi.sv
// Rare-event trigger: counts windowed cycles where all enabled nets are high and fires
// after THRESH hits, either sticky or as a re-arming pulse.
module tsc_multi
  import tsc_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned HIT_W   = 8,
  parameter int unsigned THRESH  = 128,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned MODE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  sig,
  input  logic [N_IN-1:0]  mask,
  output logic             trigger,
  output logic [HIT_W-1:0] hit_count,
  output logic             armed
);

  localparam int unsigned       IDLE_W    = tsc_idle_width(TIMEOUT);
  localparam logic [HIT_W-1:0]  THRESH_V  = HIT_W'(THRESH);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

  logic             window;
  logic [CNT_W-1:0] unused_phase;
  logic             match;
  logic             hit;

  tsc_state_t        state_q, state_d;
  logic [HIT_W-1:0]  hit_q, hit_d, hit_inc;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic              trigger_q, armed_q;

  tsc_window #(
    .CNT_W(CNT_W)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .window(window),
    .phase (unused_phase)
  );

  // An all-zero mask would otherwise match unconditionally.
  assign match = (&(sig | ~mask)) & (|mask);
  assign hit   = en & window & match;

  assign hit_inc  = hit_q + HIT_W'(1);
  assign idle_inc = idle_q + IDLE_W'(1);

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE: begin
        idle_d = '0;
        if (hit) begin
          hit_d   = HIT_W'(1);
          state_d = (THRESH == 1) ? FIRED : COUNT;
        end
      end
      COUNT: begin
        // A hit takes priority over a coincident timeout.
        if (hit) begin
          hit_d  = hit_inc;
          idle_d = '0;
          if (hit_inc == THRESH_V) begin
            state_d = FIRED;
          end
        end else if (en && (TIMEOUT != 0)) begin
          idle_d = idle_inc;
          if (idle_inc == TIMEOUT_V) begin
            hit_d   = '0;
            idle_d  = '0;
            state_d = IDLE;
          end
        end
      end
      FIRED: begin
        if ((MODE == TSC_MODE_PULSE) && en) begin
          hit_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hit_q     <= '0;
      idle_q    <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      idle_q    <= idle_d;
      trigger_q <= (state_d == FIRED);
      armed_q   <= (state_d == COUNT);
    end
  end

  assign trigger   = trigger_q;
  assign hit_count = hit_q;
  assign armed     = armed_q;

endmodule
